// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: request/ack ports of both cores plus the shared data-memory port.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // core 0
  logic              req0;
  logic              we0;
  logic              lock0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;
  // core 1
  logic              req1;
  logic              we1;
  logic              lock1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;
  // memory side and status
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              grant_id;
  logic              busy;

  // arbiter side
  modport slave (
    input  req0, we0, lock0, addr0, wdata0,
    output ack0, rdata0,
    input  req1, we1, lock1, addr1, wdata1,
    output ack1, rdata1,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output grant_id, busy
  );

  // cores plus memory, as seen from outside the arbiter
  modport master (
    output req0, we0, lock0, addr0, wdata0,
    input  ack0, rdata0,
    output req1, we1, lock1, addr1, wdata1,
    input  ack1, rdata1,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  grant_id, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of one single-port synchronous data memory
// between two cores (IDLE -> ACC -> DONE per access, back-to-back when contended).
// Optional macro DMEM_ARB_LOCK_EN: a core holding lock keeps the memory to itself.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic              gnt_q;
  logic              last_q;
  logic              ld_q;
  logic              busy_q;
  logic              ack0_q;
  logic              ack1_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  logic [1:0]        req_c;
  logic              held_idle_d;
  logic              held_done_d;
  logic              grant_d;
  logic              core_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;

  assign req_c = {bus.req1, bus.req0};

`ifdef DMEM_ARB_LOCK_EN
  logic       held_q;
  logic [1:0] lock_c;
  assign lock_c = {bus.lock1, bus.lock0};
  // held mode survives IDLE only while the owner still locks or requests
  assign held_idle_d = held_q & (lock_c[gnt_q] | req_c[gnt_q]);
  assign held_done_d = lock_c[gnt_q];
`else
  logic unused_lock;
  assign unused_lock = bus.lock0 ^ bus.lock1;
  assign held_idle_d = 1'b0;
  assign held_done_d = 1'b0;
`endif

  // grant decision: IDLE picks round-robin (or the holder), DONE hands over to the other core
  always_comb begin
    grant_d = 1'b0;
    core_d  = gnt_q;
    case (state_q)
      IDLE: begin
        if (held_idle_d) begin
          grant_d = req_c[gnt_q];
        end else if (req_c == 2'b11) begin
          grant_d = 1'b1;
          core_d  = ~last_q;
        end else begin
          grant_d = |req_c;
          core_d  = req_c[1];
        end
      end
      DONE: begin
        // the core just acked is ignored here; only the other one may follow directly
        grant_d = ~held_done_d & req_c[~gnt_q];
        core_d  = ~gnt_q;
      end
      default: grant_d = 1'b0;
    endcase
  end

  assign we_d    = core_d ? bus.we1    : bus.we0;
  assign addr_d  = core_d ? bus.addr1  : bus.addr0;
  assign wdata_d = core_d ? bus.wdata1 : bus.wdata0;

  // FSM state, memory strobes, acks and read-data holding registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      last_q      <= 1'b1;
      ld_q        <= 1'b0;
      busy_q      <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
`ifdef DMEM_ARB_LOCK_EN
      held_q      <= 1'b0;
`endif
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        IDLE: begin
`ifdef DMEM_ARB_LOCK_EN
          held_q <= held_idle_d;
`endif
        end
        ACC: begin
          state_q  <= DONE;
          last_q   <= gnt_q;
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          ld_q     <= ~mem_we_q;
          ack0_q   <= ~gnt_q;
          ack1_q   <= gnt_q;
        end
        DONE: begin
          if (ld_q && !gnt_q) rdata0_q <= bus.mem_rdata;
          if (ld_q && gnt_q)  rdata1_q <= bus.mem_rdata;
`ifdef DMEM_ARB_LOCK_EN
          held_q <= held_done_d;
`endif
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
        end
      endcase
      if (grant_d) begin
        state_q     <= ACC;
        gnt_q       <= core_d;
        busy_q      <= 1'b1;
        mem_en_q    <= 1'b1;
        mem_we_q    <= we_d;
        mem_addr_q  <= addr_d;
        mem_wdata_q <= wdata_d;
      end
    end
  end

  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.grant_id  = gnt_q;
  assign bus.busy      = busy_q;

  // memory data only arrives during DONE: a load ack forwards it, the register keeps it afterwards
  assign bus.rdata0 = (ack0_q && ld_q) ? bus.mem_rdata : rdata0_q;
  assign bus.rdata1 = (ack1_q && ld_q) ? bus.mem_rdata : rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter against a synchronous memory model.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // synchronous single-port memory; contents re-initialised while reset is low
  logic [31:0] mem [256];
  logic [31:0] mem_rdata_q;
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++)
        mem[i] <= (i == 16) ? 32'hDEAD_BEEF : (32'hA000_0000 | 32'(i));
      mem_rdata_q <= 32'h0;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      mem_rdata_q <= mem[bus.mem_addr[7:0]];
    end
  end
  assign bus.mem_rdata = mem_rdata_q;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive0(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic l);
    bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d; bus.lock0 = l;
  endtask

  task automatic drive1(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic l);
    bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d; bus.lock1 = l;
  endtask

  // protocol monitor: exclusive acks, no back-to-back acks, no req dropped before its ack
  logic prev_ack0 = 1'b0, prev_ack1 = 1'b0, pend0 = 1'b0, pend1 = 1'b0;
  always begin
    @(negedge clk);
    #2;
    check("ack_exclusive", 32'(bus.ack0 & bus.ack1), 32'd0);
    check("ack0_back_to_back", 32'(bus.ack0 & prev_ack0), 32'd0);
    check("ack1_back_to_back", 32'(bus.ack1 & prev_ack1), 32'd0);
    if (pend0 && !bus.ack0) check("req0_held", 32'(bus.req0), 32'd1);
    if (pend1 && !bus.ack1) check("req1_held", 32'(bus.req1), 32'd1);
    prev_ack0 <= bus.ack0;
    prev_ack1 <= bus.ack1;
    pend0     <= bus.req0;
    pend1     <= bus.req1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int c0, c1, n0, n1, before1;
  logic done;

  initial begin
    drive0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    drive1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_ack0", 32'(bus.ack0), 32'd0);
    check("rst_ack1", 32'(bus.ack1), 32'd0);
    check("rst_rdata0", bus.rdata0, 32'h0);
    check("rst_rdata1", bus.rdata1, 32'h0);
    check("rst_mem_en", 32'(bus.mem_en), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_grant_id", 32'(bus.grant_id), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // single load by core 0
    drive0(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    @(negedge clk);
    check("t1_mem_en", 32'(bus.mem_en), 32'd1);
    check("t1_mem_we", 32'(bus.mem_we), 32'd0);
    check("t1_mem_addr", bus.mem_addr, 32'h10);
    check("t1_grant", 32'(bus.grant_id), 32'd0);
    check("t1_busy", 32'(bus.busy), 32'd1);
    check("t1_ack0_early", 32'(bus.ack0), 32'd0);
    check("t1_ack1_acc", 32'(bus.ack1), 32'd0);
    @(negedge clk);
    check("t1_ack0", 32'(bus.ack0), 32'd1);
    check("t1_ack1_done", 32'(bus.ack1), 32'd0);
    check("t1_rdata0", bus.rdata0, 32'hDEAD_BEEF);
    check("t1_mem_en_done", 32'(bus.mem_en), 32'd0);
    drive0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("t1_idle_busy", 32'(bus.busy), 32'd0);
    check("t1_idle_ack0", 32'(bus.ack0), 32'd0);
    check("t1_ack1_idle", 32'(bus.ack1), 32'd0);
    check("t1_rdata0_hold", bus.rdata0, 32'hDEAD_BEEF);
    check("t1_mem_addr_hold", bus.mem_addr, 32'h10);

    // simultaneous store (core 0) and load (core 1) straight from reset
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    drive0(1'b1, 1'b1, 32'h20, 32'h55, 1'b0);
    drive1(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    @(negedge clk);
    check("t2_mem_en0", 32'(bus.mem_en), 32'd1);
    check("t2_mem_we0", 32'(bus.mem_we), 32'd1);
    check("t2_grant0", 32'(bus.grant_id), 32'd0);
    check("t2_mem_addr0", bus.mem_addr, 32'h20);
    check("t2_mem_wdata0", bus.mem_wdata, 32'h55);
    @(negedge clk);
    check("t2_ack0", 32'(bus.ack0), 32'd1);
    check("t2_ack1_early", 32'(bus.ack1), 32'd0);
    check("t2_rdata0_store", bus.rdata0, 32'h0);
    drive0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("t2_mem_en1", 32'(bus.mem_en), 32'd1);
    check("t2_mem_we1", 32'(bus.mem_we), 32'd0);
    check("t2_grant1", 32'(bus.grant_id), 32'd1);
    check("t2_busy_b2b", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("t2_ack1", 32'(bus.ack1), 32'd1);
    check("t2_rdata1", bus.rdata1, 32'h55);
    drive1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("t2_idle_busy", 32'(bus.busy), 32'd0);
    check("t2_rdata1_hold", bus.rdata1, 32'h55);

    // fairness under continuous contention: 20 loads, alternating owners, no idle cycle
    c0 = 0; c1 = 0;
    drive0(1'b1, 1'b0, 32'h80, 32'h0, 1'b0);
    drive1(1'b1, 1'b0, 32'hC0, 32'h0, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      check("t3_mem_en_pattern", 32'(bus.mem_en), 32'(k % 2));
      check("t3_busy", 32'(bus.busy), 32'd1);
      if (bus.mem_en) check("t3_grant_alternate", 32'(bus.grant_id), 32'(((k - 1) / 2) % 2));
      if (bus.ack0) begin
        check("t3_rdata0", bus.rdata0, 32'hA000_0000 | bus.addr0);
        c0++;
        if (c0 < 10) bus.addr0 = bus.addr0 + 32'd1;
        else drive0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      end
      if (bus.ack1) begin
        check("t3_rdata1", bus.rdata1, 32'hA000_0000 | bus.addr1);
        c1++;
        if (c1 < 10) bus.addr1 = bus.addr1 + 32'd1;
        else drive1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      end
    end
    check("t3_acks0", 32'(c0), 32'd10);
    check("t3_acks1", 32'(c1), 32'd10);
    @(negedge clk);
    check("t3_idle_busy", 32'(bus.busy), 32'd0);

    // same core again: drop req for one cycle, re-request through IDLE
    drive0(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    check("t6_ack0_first", 32'(bus.ack0), 32'd1);
    drive0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("t6_idle_busy", 32'(bus.busy), 32'd0);
    drive0(1'b1, 1'b0, 32'h11, 32'h0, 1'b0);
    @(negedge clk);
    check("t6_mem_en", 32'(bus.mem_en), 32'd1);
    check("t6_mem_addr", bus.mem_addr, 32'h11);
    check("t6_ack0_early", 32'(bus.ack0), 32'd0);
    @(negedge clk);
    check("t6_ack0_second", 32'(bus.ack0), 32'd1);
    check("t6_rdata0", bus.rdata0, 32'hA000_0011);
    drive0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);

    // reset during ACC (core 1 owns it since last=0), then core 0 wins after release
    drive0(1'b1, 1'b0, 32'h12, 32'h0, 1'b0);
    drive1(1'b1, 1'b0, 32'h13, 32'h0, 1'b0);
    @(negedge clk);
    check("t4_acc_mem_en", 32'(bus.mem_en), 32'd1);
    check("t4_acc_grant", 32'(bus.grant_id), 32'd1);
    #3 reset = 1'b0;
    #1;
    check("t4_rst_mem_en", 32'(bus.mem_en), 32'd0);
    check("t4_rst_busy", 32'(bus.busy), 32'd0);
    check("t4_rst_ack1", 32'(bus.ack1), 32'd0);
    @(negedge clk);
    check("t4_rst_hold_ack1", 32'(bus.ack1), 32'd0);
    check("t4_rst_hold_mem_en", 32'(bus.mem_en), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("t4_after_mem_en", 32'(bus.mem_en), 32'd1);
    check("t4_after_grant", 32'(bus.grant_id), 32'd0);
    check("t4_after_addr", bus.mem_addr, 32'h12);
    @(negedge clk);
    check("t4_ack0", 32'(bus.ack0), 32'd1);
    check("t4_rdata0", bus.rdata0, 32'hA000_0012);
    drive0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("t4_b2b_grant", 32'(bus.grant_id), 32'd1);
    check("t4_b2b_addr", bus.mem_addr, 32'h13);
    @(negedge clk);
    check("t4_ack1", 32'(bus.ack1), 32'd1);
    check("t4_rdata1", bus.rdata1, 32'hA000_0013);
    drive1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("t4_idle_busy", 32'(bus.busy), 32'd0);

    // lock: core 1 locks for 3 accesses while core 0 requests continuously
    n0 = 0; n1 = 0; before1 = -1; done = 1'b0;
    drive1(1'b1, 1'b0, 32'h30, 32'h0, 1'b1);
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge clk);
      if (k == 1) drive0(1'b1, 1'b0, 32'h31, 32'h0, 1'b0);
      if (bus.ack1) begin
        n1++;
        if (n1 < 3) bus.addr1 = bus.addr1 + 32'd1;
        else drive1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      end
      if (bus.ack0) begin
        if (n0 == 0) before1 = n1;
        n0++;
        drive0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      end
      if (n0 == 1 && n1 == 3) done = 1'b1;
    end
    check("t5_completed", 32'(done), 32'd1);
    check("t5_acks0", 32'(n0), 32'd1);
    check("t5_acks1", 32'(n1), 32'd3);
`ifdef DMEM_ARB_LOCK_EN
    check("t5_ack1_before_ack0", 32'(before1), 32'd3);
`else
    check("t5_ack1_before_ack0", 32'(before1), 32'd1);
`endif
    @(negedge clk);
    check("t5_idle_busy", 32'(bus.busy), 32'd0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one single-port synchronous data memory between the two cores of the dual-core CPU.
- Each core issues word-wide load/store requests on a req/ack handshake.
- The arbiter serialises the requests round-robin and drives the memory port.
- It sits between the two cpu instances and the dmem in the dual-core top level, replacing the dual-ported dmem access.

Parameters:
- ADDR_W, 32: width of request and memory address.
- DATA_W, 32: width of read/write data.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  active-low, asynchronous reset.
- req0  input  1  core 0 access request; held with addr0/we0/wdata0 stable until ack0.
- we0  input  1  core 0 store (1) / load (0).
- addr0  input  ADDR_W  core 0 address.
- wdata0  input  DATA_W  core 0 store data.
- lock0  input  1  core 0 lock request (see Optional Feature).
- ack0  output  1  one-cycle completion pulse to core 0.
- rdata0  output  DATA_W  core 0 load data, valid while ack0=1.
- req1, we1, addr1, wdata1, lock1, ack1, rdata1: same as above, for core 1.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable; only valid with mem_en.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data, valid one cycle after mem_en.
- grant_id  output  1  owner of the current or last access.
- busy  output  1  1 when state is not IDLE.

Behaviour:
- States: IDLE, ACC, DONE. Registers:
  - gnt: current owner.
  - last: last granted core; reset value 1, so core 0 wins the first tie.
- Reset (async, reset=0):
  - state=IDLE, last=1, gnt=0.
  - All outputs 0: ack0/1, rdata0/1, mem_*, grant_id, busy.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: gnt=that core, go to ACC.
  - Both req: gnt = !last, go to ACC.
- ACC (one cycle):
  - mem_en=1, mem_we=we[gnt], mem_addr=addr[gnt], mem_wdata=wdata[gnt].
  - last=gnt. Go to DONE.
- DONE (one cycle):
  - ack[gnt]=1. On a load, rdata[gnt] = mem_rdata; on a store, rdata[gnt] holds its old value.
  - The acked core's req is ignored in this cycle; it may still be high.
  - If the other core's req=1: gnt=other, go straight to ACC (back-to-back).
  - Otherwise go to IDLE.
- Timing:
  - Uncontended latency: req seen in IDLE at cycle N -> mem_en at N+1 -> ack at N+2.
  - Contended: second core acked at N+4.
- Outside ACC, mem_en=0 and mem_we=0. mem_addr and mem_wdata hold their last values.
- ack is never high for both cores in the same cycle, and never high two cycles in a row for the same core.
- rdata0/rdata1 are registered and hold until the next load ack for that core.
- grant_id=gnt, updated on entry to ACC. busy=1 in ACC and DONE.
- A req dropped before its ack is a protocol violation and the behaviour is undefined; the bench checks that the cores never do it.
- Reset mid-access (ACC or DONE):
  - The access is abandoned, no ack is issued, and mem_en falls immediately.
  - A store already clocked in ACC may have committed.
- Address and data pass through unchanged, with no width conversion and no range checking.

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- Defined:
  - If lock[gnt]=1 in DONE, the arbiter enters a held mode. In held mode only gnt may be granted, and the other core's req is ignored.
  - Held mode ends at the first DONE where lock[gnt]=0, or when gnt leaves lock=1 in IDLE with no req. Normal round-robin then resumes.
  - Reset clears held mode.
- Not defined:
  - lock0/lock1 are present but ignored; pure round-robin.

Test Plan:
- Single load: mem model returns 0xDEADBEEF at addr 0x10. Core 0 loads 0x10 -> mem_en/mem_addr=0x10 one cycle after req; ack0 two cycles after req; rdata0=0xDEADBEEF; ack1 never asserted.
- Simultaneous store and load from reset: core 0 stores 0x00000055 to 0x20 while core 1 loads 0x20 in the same cycle -> core 0 granted first (last=1 at reset); ack0 at N+2, ack1 at N+4; rdata1=0x00000055.
- Fairness under continuous contention: both cores hold req for 20 accesses -> grant_id alternates 0,1,0,1; ack count per core differs by at most 1; no idle cycle between accesses (ACC/DONE pattern).
- Reset during ACC: reset=0 asserted mid-cycle -> mem_en=0 and busy=0 immediately; no ack; after release, last=1 and a pending core-0 req completes normally.
- Lock held, with DMEM_ARB_LOCK_EN defined: core 1 holds lock1=1 for 3 accesses while core 0 requests continuously -> three core-1 acks before any ack0. Macro undefined -> acks alternate.
- Back-to-back same core: core 0 drops req for one cycle after ack0, then re-requests with core 1 idle -> re-enters via IDLE; ack0 at 2 cycles after the new req.
